// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard, write bypass and hardwired x0.
// Optional per-register even parity with error injection when REGFILE_PARITY_EN is defined.
module regfile_sb #(
    parameter  int NBITS      = 32,
    parameter  int NREGISTERS = 32,
    parameter  int NRD        = 2,
    localparam int AW         = $clog2(NREGISTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*NBITS-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [NBITS-1:0]     wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [AW:0]          pend_cnt
`ifdef REGFILE_PARITY_EN
    ,
    input  logic                 perr_inj,
    output logic [NRD-1:0]       rd_perr
`endif
);

    function automatic logic even_par(input logic [NBITS-1:0] d);
        return ^d;
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREGISTERS-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int n = 0; n < NREGISTERS; n++) begin
            c = c + {{AW{1'b0}}, v[n]};
        end
        return c;
    endfunction

    logic [NBITS-1:0]      regs_r [NREGISTERS];
    logic [NREGISTERS-1:0] pend_r;
    logic [NREGISTERS-1:0] pend_nxt_s;
    logic                  wr_ok_s;

    assign wr_ok_s = wr_en && (wr_addr != {AW{1'b0}});

    // Next pending vector: a new issue supersedes a same-cycle writeback clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int n = 0; n < NREGISTERS; n++) begin
            pend_nxt_s[n] = (iss_en && (iss_addr == AW'(n)) && (n != 0)) ? 1'b1 :
                            (wr_en && (wr_addr == AW'(n)))               ? 1'b0 :
                                                                           pend_r[n];
        end
    end

    // Register array write port; x0 stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NREGISTERS; n++) begin
                regs_r[n] <= {NBITS{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r   <= {NREGISTERS{1'b0}};
            pend_cnt <= {(AW+1){1'b0}};
        end else begin
            pend_r   <= pend_nxt_s;
            pend_cnt <= popcount(pend_nxt_s);
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NREGISTERS-1:0] par_r;

    // Stored parity bit, optionally inverted by the injection hook.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_r <= {NREGISTERS{1'b0}};
        end else if (wr_ok_s) begin
            par_r[wr_addr] <= even_par(wr_data) ^ perr_inj;
        end
    end
`endif

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr_s;
        logic          act_s;
        logic          byp_s;

        // Reset, disabled port and x0 all force zero data and no busy.
        assign addr_s = rd_addr[g*AW +: AW];
        assign act_s  = rst && rd_en[g] && (addr_s != {AW{1'b0}});
        assign byp_s  = wr_en && (wr_addr == addr_s);
        assign rd_data[g*NBITS +: NBITS] = !act_s ? {NBITS{1'b0}} :
                                           byp_s  ? wr_data : regs_r[addr_s];
        assign rd_busy[g] = act_s && !byp_s && pend_r[addr_s];
`ifdef REGFILE_PARITY_EN
        assign rd_perr[g] = act_s && !byp_s && (par_r[addr_s] != even_par(regs_r[addr_s]));
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (parity checks active when REGFILE_PARITY_EN is defined).
module tb_regfile_sb;

    localparam int NBITS = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NRD-1:0]     rd_en;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*NBITS-1:0] rd_data;
    logic [NRD-1:0]     rd_busy;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [NBITS-1:0]   wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [AW:0]        pend_cnt;
`ifdef REGFILE_PARITY_EN
    logic               perr_inj;
    logic [NRD-1:0]     rd_perr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(.NBITS(NBITS), .NREGISTERS(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
`ifdef REGFILE_PARITY_EN
        , .perr_inj(perr_inj), .rd_perr(rd_perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
`ifdef REGFILE_PARITY_EN
        perr_inj = 1'b0;
`endif
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        rst = 1'b0; idle();
        rd(5'd3, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd5;
        #1;
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
        idle();
        #7 rst = 1'b1;
        step();
        rd(5'd5, 5'd5);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL post_reset_x5 got %h exp 0", rd_data[31:0]); end
    endtask

    task automatic test_write();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        step();
        idle(); rd(5'd7, 5'd7);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x7_p0 got %h exp deadbeef", rd_data[31:0]); end
        n_checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x7_p1 got %h exp deadbeef", rd_data[63:32]); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step();
        idle(); rd(5'd0, 5'd7);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL wr_x0 got %h exp 0", rd_data[31:0]); end
        rd_en = 2'b01;
        #1;
        n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL rd_disabled got %h exp 0", rd_data[63:32]); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        step();
        wr_data = 32'hAA; rd(5'd3, 5'd7);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hAA) begin n_fail++; $display("FAIL bypass_comb got %h exp aa", rd_data[31:0]); end
        n_checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_other_port got %h exp deadbeef", rd_data[63:32]); end
        step();
        idle();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hAA) begin n_fail++; $display("FAIL bypass_stored got %h exp aa", rd_data[31:0]); end
    endtask

    task automatic test_scoreboard();
        rd(5'd4, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd4;
        #1;
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL iss_not_bypassed got %b exp 00", rd_busy); end
        step();
        idle();
        #1;
        n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL iss_busy got %b exp 11", rd_busy); end
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iss_cnt got %0d exp 1", pend_cnt); end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        #1;
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL wb_bypass_busy got %b exp 00", rd_busy); end
        step();
        idle();
        #1;
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL wb_cnt got %0d exp 0", pend_cnt); end
        iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
        step();
        idle();
        #1;
        n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL set_wins_busy got %b exp 11", rd_busy); end
        n_checks++; if (rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL set_wins_data got %h exp 55", rd_data[31:0]); end
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL set_wins_cnt got %0d exp 1", pend_cnt); end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h66;
        step();
        idle();
    endtask

    task automatic test_count();
        for (int r = 1; r < NREG; r++) begin
            iss_en = 1'b1; iss_addr = AW'(r);
            step();
        end
        idle();
        n_checks++; if (pend_cnt !== 6'd31) begin n_fail++; $display("FAIL cnt_full got %0d exp 31", pend_cnt); end
        iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
        step();
        idle(); rd(5'd2, 5'd9);
        #1;
        n_checks++; if (pend_cnt !== 6'd30) begin n_fail++; $display("FAIL cnt_30 got %0d exp 30", pend_cnt); end
        n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL cnt_busy got %b exp 10", rd_busy); end
        n_checks++; if (rd_data[31:0] !== 32'h22) begin n_fail++; $display("FAIL cnt_x2 got %h exp 22", rd_data[31:0]); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL midreset_cnt got %0d exp 0", pend_cnt); end
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL midreset_data got %h exp 0", rd_data); end
        #2 rst = 1'b1;
        step();
        rd(5'd7, 5'd2);
        #1;
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL regs_cleared got %h exp 0", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL pend_cleared got %b exp 00", rd_busy); end
        iss_en = 1'b1; iss_addr = 5'd5;
        step();
        iss_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5;
        step();
        idle(); rd(5'd5, 5'd6);
        #1;
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL set_clear_cnt got %0d exp 1", pend_cnt); end
        n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL set_clear_busy got %b exp 10", rd_busy); end
    endtask

`ifdef REGFILE_PARITY_EN
    task automatic test_parity();
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1; perr_inj = 1'b1;
        step();
        idle(); rd(5'd6, 5'd7);
        #1;
        n_checks++; if (rd_perr !== 2'b01) begin n_fail++; $display("FAIL perr_inj got %b exp 01", rd_perr); end
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h2; perr_inj = 1'b1;
        #1;
        n_checks++; if (rd_perr !== 2'b00) begin n_fail++; $display("FAIL perr_bypass got %b exp 00", rd_perr); end
        step();
        wr_data = 32'h3; perr_inj = 1'b0;
        step();
        idle();
        #1;
        n_checks++; if (rd_perr !== 2'b00) begin n_fail++; $display("FAIL perr_clean got %b exp 00", rd_perr); end
    endtask
`endif

    initial begin
        rd_en = 2'b00; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_count();
`ifdef REGFILE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
